ram_run_checker: RTL and testbench

- Synthesizable hardware successor to the bench-side sort check: after `start`, scans a window of word memory through a synchronous read port and searches for a run of RUN_LEN consecutive words holding START_VAL, START_VAL±1, and so on.
- Reports pass/fail and the first address of the run.
- Sits beside the MCU data RAM on a second read port. Used for on-chip self-check of sorting firmware and for FPGA bring-up without a simulator.

---
 rtl/rv32i_chk_pkg.sv | 17 +
 rtl/rd_tag_pipe.sv | 37 +++
 rtl/ram_run_checker.sv | 140 ++++++++++++++
 tb/tb_ram_run_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_chk_pkg.sv
// Shared state encoding and expected-value helper for the RAM run checker.
package rv32i_chk_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} chk_state_t;

    localparam int CHK_MAX_W = 64;

    // Callers truncate to their word width; the wrap survives in the low bits.
    function automatic logic [CHK_MAX_W-1:0] expected_val(
        input logic [CHK_MAX_W-1:0] start_val,
        input logic [CHK_MAX_W-1:0] cnt,
        input logic                 descend
    );
        return descend ? start_val - cnt : start_val + cnt;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Valid/address delay line that tracks each read until its data returns.
module rd_tag_pipe #(
    parameter int LAT = 1,
    parameter int AW  = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_flush,
    input  logic          i_vld,
    input  logic [AW-1:0] i_addr,
    output logic          o_vld,
    output logic [AW-1:0] o_addr
);

    logic [LAT-1:0] r_vld;
    logic [AW-1:0]  r_addr [LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            for (int i = 0; i < LAT; i++) r_addr[i] <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
        end else begin
            r_vld[0]  <= i_vld;
            r_addr[0] <= i_addr;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_addr[i] <= r_addr[i-1];
            end
        end
    end

    assign o_vld  = r_vld[LAT-1];
    assign o_addr = r_addr[LAT-1];

endmodule

// File: rtl/ram_run_checker.sv
// Scans a RAM window for RUN_LEN consecutive words START_VAL, START_VAL+-1, ...
module ram_run_checker
    import rv32i_chk_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 6,
    parameter int                RUN_LEN   = 5,
    parameter logic [DATA_W-1:0] START_VAL = DATA_W'(1),
    parameter int                RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              descend,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   scan_len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] match_addr
);

    localparam int              CW       = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(RUN_LEN - 1);
    localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    chk_state_t        r_state;
    chk_state_t        w_state_nx;
    logic              r_desc;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_idx;
    logic [ADDR_W:0]   r_ret;
    logic [CW-1:0]     r_cnt;
    logic              r_found;
    logic [ADDR_W-1:0] r_maddr;

    logic              w_accept;
    logic              w_issue;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_tag_vld;
    logic [ADDR_W-1:0] w_tag_addr;
    logic [DATA_W-1:0] w_exp;
    logic              w_eq;
    logic              w_hit;
    logic              w_ret_last;
    logic              w_issue_last;

    assign w_accept     = (r_state == IDLE) && start;
    assign w_issue      = (r_state == ISSUE);
    assign w_rd_addr    = r_base + r_idx[ADDR_W-1:0];
    assign w_exp        = DATA_W'(expected_val(CHK_MAX_W'(START_VAL),
                                               CHK_MAX_W'(r_cnt), r_desc));
    assign w_eq         = w_tag_vld && (rd_data == w_exp);
    assign w_hit        = w_eq && (r_cnt == CNT_LAST);
    assign w_ret_last   = w_tag_vld && (r_ret == r_len - LEN_ONE);
    assign w_issue_last = (r_idx == r_len - LEN_ONE);

    rd_tag_pipe #(
        .LAT (RD_LAT),
        .AW  (ADDR_W)
    ) u_tag (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_hit),
        .i_vld   (w_issue),
        .i_addr  (w_rd_addr),
        .o_vld   (w_tag_vld),
        .o_addr  (w_tag_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nx = (scan_len == '0) ? FIN : ISSUE;
            ISSUE:   if (w_hit || w_ret_last) w_state_nx = FIN;
                     else if (w_issue_last)   w_state_nx = DRAIN;
            DRAIN:   if (w_hit || w_ret_last) w_state_nx = FIN;
            FIN:     w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        rd_en      = w_issue;
        rd_addr    = w_issue ? w_rd_addr : '0;
        busy       = (r_state == ISSUE) || (r_state == DRAIN);
        done       = (r_state == FIN);
        found      = r_found;
        match_addr = r_maddr;
    end

    // A mismatching START_VAL word is itself a valid first element.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_desc  <= 1'b0;
            r_base  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_ret   <= '0;
            r_cnt   <= '0;
            r_found <= 1'b0;
            r_maddr <= '0;
        end else if (w_accept) begin
            r_desc  <= descend;
            r_base  <= base_addr;
            r_len   <= scan_len;
            r_idx   <= '0;
            r_ret   <= '0;
            r_cnt   <= '0;
            r_found <= 1'b0;
            r_maddr <= '0;
        end else begin
            if (w_issue) r_idx <= r_idx + LEN_ONE;
            if (w_tag_vld) begin
                r_ret <= r_ret + LEN_ONE;
                if (w_eq) begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == '0) r_maddr <= w_tag_addr;
                    if (w_hit)       r_found <= 1'b1;
                end else if (rd_data == START_VAL) begin
                    r_cnt   <= CNT_ONE;
                    r_maddr <= w_tag_addr;
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_run_checker.sv
// Random and directed scans against a window-search reference model.
module tb_ram_run_checker;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int RL    = 5;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          descend;
    logic [AW-1:0] base_addr;
    logic [AW:0]   scan_len;

    logic          rd_en_a, rd_en_b;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          busy_a, busy_b, done_a, done_b, found_a, found_b;
    logic [AW-1:0] maddr_a, maddr_b;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q1_b, q2_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data_a <= mem[rd_addr_a];
        q1_b      <= mem[rd_addr_b];
        q2_b      <= q1_b;
        rd_data_b <= q2_b;
    end

    ram_run_checker dut_a (
        .clk (clk), .reset (reset), .start (start), .descend (descend),
        .base_addr (base_addr), .scan_len (scan_len),
        .rd_en (rd_en_a), .rd_addr (rd_addr_a), .rd_data (rd_data_a),
        .busy (busy_a), .done (done_a), .found (found_a),
        .match_addr (maddr_a)
    );

    ram_run_checker #(
        .START_VAL (32'd5),
        .RD_LAT    (3)
    ) dut_b (
        .clk (clk), .reset (reset), .start (start), .descend (descend),
        .base_addr (base_addr), .scan_len (scan_len),
        .rd_en (rd_en_b), .rd_addr (rd_addr_b), .rd_data (rd_data_b),
        .busy (busy_b), .done (done_b), .found (found_b),
        .match_addr (maddr_b)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Earliest window position where RL words form the sequence.
    function automatic void ref_run(
        input logic [DW-1:0] sv, input int lat, input logic dsc,
        input int b, input int len,
        output logic f, output int ma, output int k, output int nrd
    );
        logic          ok;
        logic [DW-1:0] want;
        f   = 1'b0;
        ma  = 0;
        k   = (len == 0) ? 0 : len + lat;
        nrd = len;
        for (int e = RL - 1; e < len && !f; e++) begin
            ok = 1'b1;
            for (int j = 0; j < RL; j++) begin
                want = dsc ? sv - DW'(j) : sv + DW'(j);
                if (mem[(b + e - RL + 1 + j) % DEPTH] !== want) ok = 1'b0;
            end
            if (ok) begin
                f   = 1'b1;
                ma  = (b + e - RL + 1) % DEPTH;
                k   = e + lat + 1;
                nrd = (len < k) ? len : k;
            end
        end
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    task automatic plant(input int p, input int sv, input logic dsc, input int n);
        for (int j = 0; j < n; j++)
            mem[(p + j) % DEPTH] = dsc ? DW'(sv - j) : DW'(sv + j);
    endtask

    task automatic run(input logic dsc, input int b, input int len, input bit poke);
        logic fa, fb;
        int   ma, mb, ka, kb, na, nb;
        int   da = -1, db = -1, ca = 0, cb = 0, ea = 0, eb = 0;
        ref_run(32'd1, 1, dsc, b, len, fa, ma, ka, na);
        ref_run(32'd5, 3, dsc, b, len, fb, mb, kb, nb);
        @(negedge clk);
        descend   = dsc;
        base_addr = AW'(b);
        scan_len  = (AW+1)'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200 && (da < 0 || db < 0); k++) begin
            if (k == 0) begin
                check("busy_first_a", busy_a, len != 0);
                check("busy_first_b", busy_b, len != 0);
            end
            if (rd_en_a) begin
                if (rd_addr_a != AW'(b + ca)) ea++;
                ca++;
            end
            if (rd_en_b) begin
                if (rd_addr_b != AW'(b + cb)) eb++;
                cb++;
            end
            if (da < 0 && done_a) begin
                da = k;
                check("busy_at_done_a", busy_a, 0);
            end
            if (db < 0 && done_b) begin
                db = k;
                check("busy_at_done_b", busy_b, 0);
            end
            if (poke && k == 1) begin
                start     = 1'b1;
                base_addr = AW'($urandom);
                scan_len  = (AW+1)'($urandom_range(1, 64));
                descend   = ~dsc;
            end
            if (poke && k == 2) start = 1'b0;
            @(posedge clk); #1;
        end
        check("done_cycle_a", da, ka);
        check("done_cycle_b", db, kb);
        check("found_a", found_a, fa);
        check("found_b", found_b, fb);
        if (fa) check("match_addr_a", maddr_a, ma);
        if (fb) check("match_addr_b", maddr_b, mb);
        check("rd_count_a", ca, na);
        check("rd_count_b", cb, nb);
        check("rd_addr_seq_a", ea, 0);
        check("rd_addr_seq_b", eb, 0);
        check("done_pulse", {done_a, done_b}, 0);
    endtask

    task automatic reset_mid();
        int dn = 0;
        @(negedge clk);
        descend   = 1'b0;
        base_addr = AW'($urandom);
        scan_len  = 7'd50;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", {busy_a, busy_b, rd_en_a, rd_en_b}, 4'b1111);
        #1 reset = 1'b0;
        #1;
        check("rst_ctl", {rd_en_a, rd_en_b, busy_a, busy_b,
                          done_a, done_b, found_a, found_b}, 0);
        check("rst_addr", {rd_addr_a, rd_addr_b, maddr_a, maddr_b}, 0);
        repeat (4) begin
            @(posedge clk); #1;
            if (done_a || done_b) dn++;
        end
        check("rst_no_done", dn, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        descend   = 1'b0;
        base_addr = '0;
        scan_len  = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {rd_en_a, rd_en_b, busy_a, busy_b,
                            done_a, done_b, found_a, found_b}, 0);
        check("reset_addr", {rd_addr_a, rd_addr_b, maddr_a, maddr_b}, 0);
        @(negedge clk);
        reset = 1'b1;

        plant(10, 1, 1'b0, RL);
        run(1'b0, 0, 64, 1'b0);

        clear_mem();
        mem[3] = 32'd1;
        mem[4] = 32'd2;
        plant(5, 1, 1'b0, RL);
        run(1'b0, 0, 20, 1'b0);

        clear_mem();
        plant(20, 5, 1'b1, RL);
        run(1'b1, 0, 64, 1'b0);
        run(1'b0, 0, 64, 1'b0);

        clear_mem();
        plant(60, 1, 1'b0, RL);
        run(1'b0, 60, 8, 1'b0);
        run(1'b0, 0, 64, 1'b0);

        run(1'b0, 5, 0, 1'b0);

        clear_mem();
        plant(30, 1, 1'b0, RL);
        plant(40, 5, 1'b1, RL);
        run(1'b0, 0, 64, 1'b1);
        run(1'b1, 0, 64, 1'b1);

        reset_mid();
        run(1'b1, 0, 64, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int  b, len;
            bit  dsc;
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 6));
            if ($urandom_range(0, 2) != 0)
                plant($urandom_range(0, 63), ($urandom_range(0, 1) != 0) ? 5 : 1,
                      1'($urandom_range(0, 1)), $urandom_range(RL - 1, RL));
            dsc = 1'($urandom_range(0, 1));
            b   = $urandom_range(0, 63);
            len = $urandom_range(0, 64);
            run(dsc, b, len, len >= 2 && $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
